mul_div_unit: RTL and testbench

Multi-cycle 32-bit multiply/divide engine that produces the 64-bit Hi:Lo result consumed by the Hi/Lo register file.
- Accepts operands with a start pulse, iterates one bit per clock, then presents a 64-bit ans with a one-cycle done strobe.
- Sits between the ALU-side operand buses and the Hi/Lo register; the control unit uses busy to stall dependent MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide engine producing a 64-bit Hi:Lo result.
// Latency: done strobes 32 clocks after the accepting edge; one op per 33 cycles.
// Backpressure: start is honoured only while busy=0; starts during CALC are dropped.
// Optional feature macro SIGNED_OPS_EN: when defined, op[1] selects signed MULT/DIV.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   ans
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  // Multiplicand for multiply, divisor for divide.
  logic [WIDTH-1:0]     opb_q, opb_d;
  // Multiply: {partial product hi, multiplier/product lo}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   ans_q, ans_d;
  logic                 neg_q_q, neg_q_d;   // negate product / quotient
  logic                 neg_r_q, neg_r_d;   // negate remainder

  // Operand conditioning applied when an operation is accepted.
  logic                 sgn_a, sgn_b;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // One iteration of each algorithm, computed from the working registers.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_qbit;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step_next;

  // Final result after sign correction and divide-by-zero override.
  logic [WIDTH-1:0]     fin_quo;
  logic [WIDTH-1:0]     fin_rem;
  logic [2*WIDTH-1:0]   fin_prod;
  logic [2*WIDTH-1:0]   result;

`ifdef SIGNED_OPS_EN
  // Signed ops run the unsigned core on magnitudes; signs are remembered for the fix-up.
  always_comb begin
    sgn_a = op[1] & a[WIDTH-1];
    sgn_b = op[1] & b[WIDTH-1];
    mag_a = sgn_a ? -a : a;
    mag_b = sgn_b ? -b : b;
  end
`else
  logic unused_op1;
  assign unused_op1 = op[1];

  // Without signed support op[1] is ignored and operands pass through unchanged.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    mag_a = a;
    mag_b = b;
  end
`endif

  // Single shift-add multiply step and single restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_qbit  = ~div_diff[WIDTH+1];
    // The restored/subtracted remainder is always below the divisor, so it fits WIDTH bits.
    div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};

    step_next = is_div_q ? div_next : mul_next;
  end

  // Result assembly on the last iteration: sign fix-up and divide-by-zero rule.
  always_comb begin
    fin_prod = neg_q_q ? -step_next : step_next;
    fin_quo  = neg_q_q ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    fin_rem  = neg_r_q ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      result = fin_prod;
    end else if (div0_q) begin
      result = {a_raw_q, {WIDTH{1'b1}}};
    end else begin
      result = {fin_rem, fin_quo};
    end
  end

  // Next-state and working-register updates for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    a_raw_d  = a_raw_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    ans_d    = ans_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (start) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[0];
          div0_d   = op[0] && (b == '0);
          a_raw_d  = a;
          neg_q_d  = sgn_a ^ sgn_b;
          neg_r_d  = sgn_a;
          if (op[0]) begin
            opb_d = mag_b;
            acc_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opb_d = mag_a;
            acc_d = {{WIDTH{1'b0}}, mag_b};
          end
        end
      end
      CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          ans_d   = result;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      ans_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      a_raw_q  <= a_raw_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      ans_q    <= ans_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign ans  = ans_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic model.
// The model tracks each accepted op as a pending result due 32 edges later.
// Outputs are compared every falling edge outside reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [63:0] ans;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .ans   (ans)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result straight from integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] f_op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    bit sgn;
`ifdef SIGNED_OPS_EN
    sgn = f_op[1];
`else
    sgn = 1'b0;
`endif
    if (!f_op[0]) begin
      if (sgn) begin
        sx = $signed(x);
        sy = $signed(y);
        p  = sx * sy;
      end else begin
        p = {32'd0, x} * {32'd0, y};
      end
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFFFFFF};
    if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  // Model: an accepted op produces its result 32 edges later; starts while pending are dropped.
  bit          m_pend = 1'b0;
  bit          m_done = 1'b0;
  bit          m_acc;
  int          m_left = 0;
  logic [63:0] m_ans = 64'd0;
  logic [63:0] m_next = 64'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_ans  = 64'd0;
    end else begin
      m_acc  = start && !m_pend;
      m_done = 1'b0;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 1'b0;
          m_ans  = m_next;
          m_done = 1'b1;
        end
      end
      if (m_acc) begin
        m_pend = 1'b1;
        m_left = 32;
        m_next = ref_res(op, a, b);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("cyc_busy", {63'd0, busy}, {63'd0, m_pend});
      chk("cyc_done", {63'd0, done}, {63'd0, m_done});
      chk("cyc_ans", ans, m_ans);
    end
  end

  task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int acc);
    @(posedge clk);
    #1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = edge_cnt;
  endtask

  task automatic wait_done(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    bit saw;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_ans", ans, 64'd0);

    // Max unsigned product and exact latency.
    do_start(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, acc);
    wait_done(40);
    chk("multu_latency", 64'(edge_cnt - acc), 64'd32);
    chk("multu_ans", ans, 64'hFFFFFFFE_00000001);
    chk("multu_busy_in_done", {63'd0, busy}, 64'd0);

    // Unsigned divide and divide by zero.
    do_start(2'b01, 32'd100, 32'd7, acc);
    wait_done(40);
    chk("divu_100_7", ans, {32'd2, 32'd14});
    do_start(2'b01, 32'd5, 32'd0, acc);
    wait_done(40);
    chk("divu_by_zero", ans, {32'd5, 32'hFFFFFFFF});

    // Start while busy is ignored; back-to-back launch from the done cycle.
    do_start(2'b00, 32'd3, 32'd4, acc);
    repeat (9) @(posedge clk);
    #1;
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(40);
    chk("busy_start_ignored", ans, 64'd12);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc = edge_cnt;
    wait_done(40);
    chk("back_to_back_ans", ans, 64'd81);
    chk("back_to_back_latency", 64'(edge_cnt - acc), 64'd32);

    // Asynchronous reset mid-operation discards it.
    do_start(2'b01, 32'd1000, 32'd3, acc);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_ans", ans, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    chk("no_done_after_reset", {63'd0, saw}, 64'd0);

    // op[1] handling.
    do_start(2'b10, 32'hFFFFFFFF, 32'd2, acc);
    wait_done(40);
`ifdef SIGNED_OPS_EN
    chk("mult_neg1_x2", ans, 64'hFFFFFFFF_FFFFFFFE);
    do_start(2'b10, 32'hFFFFFFFD, 32'd5, acc);
    wait_done(40);
    chk("mult_m3_x5", ans, 64'hFFFFFFFF_FFFFFFF1);
    do_start(2'b11, 32'hFFFFFFF9, 32'd2, acc);
    wait_done(40);
    chk("div_m7_2", ans, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_start(2'b11, 32'h80000000, 32'hFFFFFFFF, acc);
    wait_done(40);
    chk("div_min_m1", ans, {32'h00000000, 32'h80000000});
    do_start(2'b11, 32'hFFFFFFF9, 32'd0, acc);
    wait_done(40);
    chk("div_signed_by_zero", ans, {32'hFFFFFFF9, 32'hFFFFFFFF});
`else
    chk("op10_unsigned", ans, 64'h00000001_FFFFFFFE);
    do_start(2'b11, 32'hFFFFFFF9, 32'd2, acc);
    wait_done(40);
    chk("op11_unsigned", ans, {32'd1, 32'h7FFFFFFC});
`endif

    // Random traffic, including starts during busy and back-to-back launches.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
